// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode map,
// ALU operation encodings and the sequencer state type.
package cpu_ctrl_pkg;

  // Opcode field values (top bits of the instruction word)
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_LOADI = 4'h7;
  localparam logic [3:0] OP_JUMP  = 4'h8;
  localparam logic [3:0] OP_LT    = 4'h9;
  localparam logic [3:0] OP_NOT   = 4'hA;
  localparam logic [3:0] OP_BRZ   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU operation select encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b100;
  localparam logic [2:0] ALU_LT  = 3'b101;

  // Instruction sequencer states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } ctrl_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: produces the datapath control word and
// the instruction-class flags the sequencer uses to pick its path.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                is_mem,
  output logic                is_store,
  output logic                is_wb,
  output logic                is_jump,
  output logic                is_brz,
  output logic                is_halt,
  output logic                is_illegal
);

  // Map each opcode to its control word; unknown opcodes flag illegal
  always_comb begin
    alu_op     = '0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    is_mem     = 1'b0;
    is_store   = 1'b0;
    is_wb      = 1'b0;
    is_jump    = 1'b0;
    is_brz     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OPCODE_W'(OP_NOP): begin
      end
      OPCODE_W'(OP_ADD): begin
        alu_op = ALU_OP_W'(ALU_ADD);
        is_wb  = 1'b1;
      end
      OPCODE_W'(OP_SUB): begin
        alu_op = ALU_OP_W'(ALU_SUB);
        is_wb  = 1'b1;
      end
      OPCODE_W'(OP_AND): begin
        alu_op = ALU_OP_W'(ALU_AND);
        is_wb  = 1'b1;
      end
      OPCODE_W'(OP_OR): begin
        alu_op = ALU_OP_W'(ALU_OR);
        is_wb  = 1'b1;
      end
      OPCODE_W'(OP_LOAD): begin
        alu_op     = ALU_OP_W'(ALU_ADD);
        mem_to_reg = 1'b1;
        is_mem     = 1'b1;
      end
      OPCODE_W'(OP_STORE): begin
        alu_op   = ALU_OP_W'(ALU_ADD);
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OPCODE_W'(OP_LOADI): begin
        alu_op  = ALU_OP_W'(ALU_ADD);
        alu_src = 1'b1;
        is_wb   = 1'b1;
      end
      OPCODE_W'(OP_JUMP): begin
        is_jump = 1'b1;
      end
      OPCODE_W'(OP_LT): begin
        alu_op = ALU_OP_W'(ALU_LT);
        is_wb  = 1'b1;
      end
      OPCODE_W'(OP_NOT): begin
        alu_op = ALU_OP_W'(ALU_NOT);
        is_wb  = 1'b1;
      end
      OPCODE_W'(OP_BRZ): begin
        is_brz = 1'b1;
      end
      OPCODE_W'(OP_HALT): begin
        is_halt = 1'b1;
      end
      default: begin
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, owns the instruction register and
// the req/ack handshakes with instruction and data memory.
//
// Handshake: a request (imem_req / dmem_req) is raised on entry to the
// owning state and held, unchanged, until the cycle in which the matching
// ack is seen high at a rising clock edge; that cycle completes the
// transfer. Acks seen while the matching request is low are ignored.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int INSTR_W  = 8,
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  input  logic                alu_zero,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [INSTR_W-1:0]  ir,
  output logic                reg_write,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_to_reg,
  output logic                pc_write,
  output logic                pc_src,
  output logic                halted,
  output logic                illegal
);

  ctrl_state_t         state;
  logic [OPCODE_W-1:0] opcode;

  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_alu_src;
  logic                dec_mem_to_reg;
  logic                is_mem;
  logic                is_store;
  logic                is_wb;
  logic                is_jump;
  logic                is_brz;
  logic                is_halt;
  logic                is_illegal;
  logic                ctrl_active;
  logic                is_flow;

  assign opcode = ir[INSTR_W-1 -: OPCODE_W];

  ctrl_decode #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .opcode     (opcode),
    .alu_op     (dec_alu_op),
    .alu_src    (dec_alu_src),
    .mem_to_reg (dec_mem_to_reg),
    .is_mem     (is_mem),
    .is_store   (is_store),
    .is_wb      (is_wb),
    .is_jump    (is_jump),
    .is_brz     (is_brz),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // NOP, JUMP, BRZ and illegal opcodes retire straight out of EXECUTE
  assign is_flow = !is_mem && !is_wb && !is_halt;

  // Sequencer: state, instruction register and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (is_halt) begin
            state <= S_HALT;
          end else if (is_mem) begin
            state <= S_MEM;
          end else if (is_wb) begin
            state <= S_WRITEBACK;
          end else begin
            if (is_illegal) begin
              illegal <= 1'b1;
            end
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            state <= is_store ? S_FETCH : S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          state <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Control word is only driven while an instruction is past DECODE
  assign ctrl_active = (state == S_EXECUTE) || (state == S_MEM) ||
                       (state == S_WRITEBACK);

  // Output decode from registered state and ir. STORE retires in its
  // dmem_ack cycle, so that pc_write term necessarily follows dmem_ack;
  // pc_src follows alu_zero only for BRZ in EXECUTE.
  always_comb begin
    imem_req   = (state == S_FETCH);
    dmem_req   = (state == S_MEM);
    dmem_we    = (state == S_MEM) && is_store;
    reg_write  = (state == S_WRITEBACK);
    halted     = (state == S_HALT);
    alu_op     = ctrl_active ? dec_alu_op : '0;
    alu_src    = ctrl_active && dec_alu_src;
    mem_to_reg = ctrl_active && dec_mem_to_reg;
    pc_write   = ((state == S_EXECUTE) && is_flow) ||
                 ((state == S_MEM) && is_store && dmem_ack) ||
                 (state == S_WRITEBACK);
    pc_src     = (state == S_EXECUTE) && (is_jump || (is_brz && alu_zero));
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each task walks one instruction
// scenario cycle by cycle and compares outputs to hand-derived values.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [7:0] imem_rdata;
  logic       imem_ack;
  logic       dmem_ack;
  logic       alu_zero;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic [7:0] ir;
  logic       reg_write;
  logic       alu_src;
  logic [2:0] alu_op;
  logic       mem_to_reg;
  logic       pc_write;
  logic       pc_src;
  logic       halted;
  logic       illegal;

  int checks = 0;
  int fails  = 0;

  multicycle_control #(
    .INSTR_W  (8),
    .OPCODE_W (4),
    .ALU_OP_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .alu_zero   (alu_zero),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir         (ir),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .halted     (halted),
    .illegal    (illegal)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present an instruction with immediate ack while in FETCH; ends in DECODE
  task automatic give_instr(input logic [7:0] instr);
    imem_rdata = instr;
    imem_ack   = 1'b1;
    step();
    imem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    dmem_ack   = 1'b0;
    alu_zero   = 1'b0;
    imem_rdata = 8'hFF;
    repeat (3) @(posedge clk);
    #2;
    outs = {imem_req, dmem_req, dmem_we, reg_write, alu_src, alu_op,
            mem_to_reg, pc_write, pc_src, halted, illegal};
    checks++;
    if (outs !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 13'd0);
    end
    checks++;
    if (ir !== 8'h00) begin
      fails++;
      $display("FAIL reset_ir: got %h expected 00", ir);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_release: imem_req=%b expected 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1) begin
      fails++;
      $display("FAIL fetch_after_idle: imem_req=%b expected 1", imem_req);
    end
  endtask

  task automatic test_add();
    logic [12:0] outs;
    give_instr(8'h12);
    #1;
    checks++;
    if (ir !== 8'h12) begin
      fails++;
      $display("FAIL add_ir: got %h expected 12", ir);
    end
    outs = {imem_req, dmem_req, dmem_we, reg_write, alu_src, alu_op,
            mem_to_reg, pc_write, pc_src, halted, illegal};
    checks++;
    if (outs !== 13'd0) begin
      fails++;
      $display("FAIL add_decode_quiet: got %b expected %b", outs, 13'd0);
    end
    step();
    #1;
    checks++;
    if ({reg_write, pc_write, alu_op} !== 5'b00_000) begin
      fails++;
      $display("FAIL add_execute: {rw,pw,op}=%b expected 00000",
               {reg_write, pc_write, alu_op});
    end
    step();
    #1;
    checks++;
    if ({reg_write, pc_write, pc_src, alu_op} !== 6'b110_000) begin
      fails++;
      $display("FAIL add_writeback: {rw,pw,ps,op}=%b expected 110000",
               {reg_write, pc_write, pc_src, alu_op});
    end
    step();
    #1;
    checks++;
    if ({imem_req, reg_write, pc_write} !== 3'b100) begin
      fails++;
      $display("FAIL add_refetch: {ireq,rw,pw}=%b expected 100",
               {imem_req, reg_write, pc_write});
    end
  endtask

  task automatic test_alu_ops();
    logic [7:0] instr_tab [4];
    logic [2:0] op_tab    [4];
    logic       src_tab   [4];
    instr_tab = '{8'h25, 8'h93, 8'hA1, 8'h7F};
    op_tab    = '{3'b001, 3'b101, 3'b100, 3'b000};
    src_tab   = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      give_instr(instr_tab[i]);
      step();
      #1;
      checks++;
      if ({alu_op, alu_src, pc_write} !== {op_tab[i], src_tab[i], 1'b0}) begin
        fails++;
        $display("FAIL alu_execute[%0d]: {op,src,pw}=%b expected %b", i,
                 {alu_op, alu_src, pc_write}, {op_tab[i], src_tab[i], 1'b0});
      end
      step();
      #1;
      checks++;
      if ({alu_op, alu_src, reg_write, pc_write, mem_to_reg} !==
          {op_tab[i], src_tab[i], 3'b110}) begin
        fails++;
        $display("FAIL alu_writeback[%0d]: {op,src,rw,pw,m2r}=%b expected %b", i,
                 {alu_op, alu_src, reg_write, pc_write, mem_to_reg},
                 {op_tab[i], src_tab[i], 3'b110});
      end
      step();
    end
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      fail_line("alu_refetch");
    end
  endtask

  task automatic fail_line(input string name);
    fails++;
    $display("FAIL %s: imem_req=%b expected 1", name, imem_req);
  endtask

  task automatic test_load_wait();
    give_instr(8'h53);
    step();
    #1;
    checks++;
    if ({dmem_req, pc_write, mem_to_reg} !== 3'b001) begin
      fails++;
      $display("FAIL load_execute: {dreq,pw,m2r}=%b expected 001",
               {dmem_req, pc_write, mem_to_reg});
    end
    step();
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      checks++;
      if ({dmem_req, dmem_we, pc_write, reg_write} !== 4'b1000) begin
        fails++;
        $display("FAIL load_mem[%0d]: {dreq,we,pw,rw}=%b expected 1000", i,
                 {dmem_req, dmem_we, pc_write, reg_write});
      end
      step();
    end
    dmem_ack = 1'b0;
    #1;
    checks++;
    if ({mem_to_reg, reg_write, pc_write, dmem_req} !== 4'b1110) begin
      fails++;
      $display("FAIL load_writeback: {m2r,rw,pw,dreq}=%b expected 1110",
               {mem_to_reg, reg_write, pc_write, dmem_req});
    end
    step();
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      fail_line("load_refetch");
    end
  endtask

  task automatic test_store();
    give_instr(8'h60);
    step();
    #1;
    checks++;
    if ({dmem_req, pc_write, reg_write} !== 3'b000) begin
      fails++;
      $display("FAIL store_execute: {dreq,pw,rw}=%b expected 000",
               {dmem_req, pc_write, reg_write});
    end
    step();
    dmem_ack = 1'b1;
    #1;
    checks++;
    if ({dmem_req, dmem_we, pc_write, reg_write} !== 4'b1110) begin
      fails++;
      $display("FAIL store_mem: {dreq,we,pw,rw}=%b expected 1110",
               {dmem_req, dmem_we, pc_write, reg_write});
    end
    step();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if ({imem_req, reg_write, dmem_we} !== 3'b100) begin
      fails++;
      $display("FAIL store_refetch: {ireq,rw,we}=%b expected 100",
               {imem_req, reg_write, dmem_we});
    end
  endtask

  task automatic test_branch();
    // BRZ taken; pc_src must stay low in DECODE even with alu_zero high
    give_instr(8'hB4);
    alu_zero = 1'b1;
    #1;
    checks++;
    if ({pc_write, pc_src} !== 2'b00) begin
      fails++;
      $display("FAIL brz_decode: {pw,ps}=%b expected 00", {pc_write, pc_src});
    end
    step();
    #1;
    checks++;
    if ({pc_write, pc_src} !== 2'b11) begin
      fails++;
      $display("FAIL brz_taken: {pw,ps}=%b expected 11", {pc_write, pc_src});
    end
    step();
    #1;
    checks++;
    if ({imem_req, pc_write, pc_src} !== 3'b100) begin
      fails++;
      $display("FAIL brz_refetch: {ireq,pw,ps}=%b expected 100",
               {imem_req, pc_write, pc_src});
    end
    // BRZ not taken
    give_instr(8'hB4);
    alu_zero = 1'b0;
    step();
    #1;
    checks++;
    if ({pc_write, pc_src} !== 2'b10) begin
      fails++;
      $display("FAIL brz_not_taken: {pw,ps}=%b expected 10", {pc_write, pc_src});
    end
    step();
    // JUMP selects the target regardless of alu_zero
    give_instr(8'h8C);
    step();
    #1;
    checks++;
    if ({pc_write, pc_src, reg_write} !== 3'b110) begin
      fails++;
      $display("FAIL jump_execute: {pw,ps,rw}=%b expected 110",
               {pc_write, pc_src, reg_write});
    end
    step();
  endtask

  task automatic test_illegal_halt();
    give_instr(8'hC0);
    step();
    #1;
    checks++;
    if ({pc_write, pc_src, illegal} !== 3'b100) begin
      fails++;
      $display("FAIL illegal_execute: {pw,ps,ill}=%b expected 100",
               {pc_write, pc_src, illegal});
    end
    step();
    #1;
    checks++;
    if ({illegal, imem_req} !== 2'b11) begin
      fails++;
      $display("FAIL illegal_continue: {ill,ireq}=%b expected 11",
               {illegal, imem_req});
    end
    give_instr(8'hF0);
    step();
    #1;
    checks++;
    if ({pc_write, halted, illegal} !== 3'b001) begin
      fails++;
      $display("FAIL halt_execute: {pw,halt,ill}=%b expected 001",
               {pc_write, halted, illegal});
    end
    step();
    imem_rdata = 8'h12;
    imem_ack   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if ({imem_req, halted, illegal, ir} !== {3'b011, 8'hF0}) begin
        fails++;
        $display("FAIL halt_hold[%0d]: {ireq,halt,ill,ir}=%b expected %b", i,
                 {imem_req, halted, illegal, ir}, {3'b011, 8'hF0});
      end
      step();
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    // Leave HALT via reset
    rst_n = 1'b0;
    #1;
    checks++;
    if ({halted, illegal} !== 2'b00) begin
      fails++;
      $display("FAIL halt_reset: {halt,ill}=%b expected 00", {halted, illegal});
    end
    step();
    rst_n = 1'b1;
    step();
    // Now in FETCH with no ack: request must be held
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (imem_req !== 1'b1) begin
        fail_line("fetch_wait");
      end
      step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, ir} !== 9'd0) begin
      fails++;
      $display("FAIL async_reset: {ireq,ir}=%b expected 0", {imem_req, ir});
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: imem_req=%b expected 0", imem_req);
    end
    step();
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      fail_line("reset_refetch");
    end
  endtask

  task automatic test_back_to_back();
    // NOP retires in three cycles: FETCH, DECODE, EXECUTE
    give_instr(8'h05);
    step();
    #1;
    checks++;
    if ({pc_write, pc_src, reg_write} !== 3'b100) begin
      fails++;
      $display("FAIL nop_execute: {pw,ps,rw}=%b expected 100",
               {pc_write, pc_src, reg_write});
    end
    step();
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      fail_line("nop_refetch");
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_load_wait();
    test_store();
    test_branch();
    test_illegal_halt();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
